// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one decimal-corrected digit slice,
// least-significant digit first, with valid/ready handshakes on both sides.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic                busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_r, b_r;
  logic            sub_r, c_r;
  logic [CW-1:0]   cnt;
  logic            last;

  logic [3:0]      x, bd, y, digit;
  logic [4:0]      raw, raw_adj;
  logic            c_nxt;
  logic            bad_in;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign last      = (cnt == CW'(DIGITS - 1));

  // Subtraction runs as A + nines-complement(B) with the borrow folded into the carry.
  always_comb begin
    x       = a_r[4*cnt +: 4];
    bd      = b_r[4*cnt +: 4];
    y       = sub_r ? (4'd9 - bd) : bd;
    raw     = {1'b0, x} + {1'b0, y} + {4'd0, c_r};
    raw_adj = raw + 5'd6;
    if (raw > 5'd9) begin
      digit = raw_adj[3:0];
      c_nxt = 1'b1;
    end else begin
      digit = raw[3:0];
      c_nxt = 1'b0;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
      c_r   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            c_r   <= sub ? ~cin : cin;
            cnt   <= '0;
            err   <= bad_in;
          end
        end
        RUN: begin
          sum[4*cnt +: 4] <= digit;
          c_r             <= c_nxt;
          // Wrap so the slice index never leaves the operand range.
          cnt             <= last ? '0 : cnt + CW'(1);
          if (last) cout  <= sub_r ? ~c_nxt : c_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial: directed cases plus random
// transactions checked against an integer-arithmetic decimal model.
module tb_bcd_addsub_serial;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MOD = 10000;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, cout, err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       input logic ms, output logic [W-1:0] s, output logic c);
    int t;
    if (!ms) begin
      t = bcd2int(ma) + bcd2int(mb) + int'(mc);
      c = (t >= MOD);
      s = int2bcd(t % MOD);
    end else begin
      t = bcd2int(ma) - bcd2int(mb) - int'(mc);
      c = (t < 0);
      s = int2bcd((t + MOD) % MOD);
    end
  endtask

  task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check("in_ready_wait", in_ready, 1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check("busy_after_accept", busy, 1);
    check("in_ready_in_run", in_ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, D);
  endtask

  task automatic accept_out(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_cleared", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  task automatic run_txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts, input logic [W-1:0] es,
                         input logic ec, input logic ee, input int delay);
    start(ta, tb, tc, ts);
    wait_done();
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_err"}, err, ee);
    accept_out(delay);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rc, rs, ec;
    int           seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn("add_basic",  16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 0);
    run_txn("add_ripple", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_txn("add_cin",    16'h0009, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1);
    run_txn("sub_basic",  16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b0, 1'b0, 0);
    run_txn("sub_neg",    16'h0001, 16'h0002, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 0);
    run_txn("sub_bin",    16'h5000, 16'h4999, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 2);
    // 0xA in digit 1 overflows the slice: digit 0 with carry into digit 2.
    run_txn("invalid",    16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 0);
    run_txn("after_inv",  16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    // Backpressure in DONE with in_valid asserted, then a back-to-back request.
    start(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done();
    a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_sum", sum, 16'h2345);
      check("bp_cout", cout, 0);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done();
    check("b2b_sum", sum, 16'h0003);
    check("b2b_cout", cout, 0);
    accept_out(0);

    // Reset two cycles after accept drops the transaction.
    start(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_valid_after_rst", seen, 0);
    run_txn("post_rst", 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = int2bcd(int'($urandom_range(0, MOD - 1)));
      rb = int2bcd(int'($urandom_range(0, MOD - 1)));
      rc = 1'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rc, rs, es, ec);
      run_txn("rand", ra, rb, rc, rs, es, ec, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
